// File: rtl/jogo_pkg.sv
// Shared state codes and reset values for the progressive-round memory game.
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROX_JOGADA = 4'h5,
        PROX_RODADA = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam estado_t ESTADO_RESET = INICIAL;
    localparam logic    BIT_RESET    = 1'b0;

    function automatic logic estado_final(input estado_t e);
        logic f;
        case (e)
            FIM_ACERTO:  f = 1'b1;
            FIM_ERRO:    f = 1'b1;
            FIM_TIMEOUT: f = 1'b1;
            default:     f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/jogo_memoria_rodadas_contador_timeout.sv
// Saturating per-move timeout counter: fim rises on the M-th consecutive counting cycle.
module contador_timeout #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);
    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LIMITE = W'(M - 1);

    logic [W-1:0] cont_q;
    logic [W-1:0] cont_d;

    // next count: clear, advance, or hold at the limit
    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (conta && (cont_q != LIMITE)) begin
            cont_d = cont_q + W'(1);
        end else begin
            cont_d = cont_q;
        end
    end

    // count register
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim = conta && (cont_q == LIMITE);

endmodule

// File: rtl/jogo_memoria_rodadas.sv
// Progressive-round sequence game: round r replays ROM items 0..r, win after PROF rounds.
module jogo_memoria_rodadas
    import jogo_pkg::*;
#(
    parameter int N_BOTOES       = 4,
    parameter int PROF           = 16,
    parameter int W_END          = $clog2(PROF),
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] chaves,
    input  logic [N_BOTOES-1:0] mem_data,
    output logic [W_END-1:0]    mem_addr,
    output logic [W_END-1:0]    rodada,
    output logic [N_BOTOES-1:0] leds,
    output logic                acertou,
    output logic                errou,
    output logic                pronto,
    output logic                db_timeout,
    output logic                db_jogada,
    output logic [3:0]          db_estado
);
    localparam logic [W_END-1:0] ULTIMA = W_END'(PROF - 1);

    estado_t             estado_q, estado_d;
    logic [W_END-1:0]    mem_addr_q, mem_addr_d;
    logic [W_END-1:0]    rodada_q, rodada_d;
    logic [N_BOTOES-1:0] leds_q, leds_d;
    logic [N_BOTOES-1:0] chaves_prev_q;
    logic                jogada_q, jogada_d;
    logic                acertou_q, acertou_d;
    logic                errou_q, errou_d;
    logic                pronto_q, pronto_d;
    logic                db_timeout_q, db_timeout_d;
    logic [3:0]          db_estado_q;
    logic                fim_timeout_s;
    logic                em_espera_s;

    assign em_espera_s = (estado_q == ESPERA);

    contador_timeout #(
        .M(TIMEOUT_CICLOS)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (~em_espera_s),
        .conta (em_espera_s),
        .fim   (fim_timeout_s)
    );

    // a move is a zero-to-nonzero transition of the button vector
    always_comb begin
        jogada_d = 1'b0;
        if ((chaves_prev_q == '0) && (chaves != '0)) begin
            jogada_d = 1'b1;
        end else begin
            jogada_d = 1'b0;
        end
    end

    // game sequencing and datapath next-state
    always_comb begin
        estado_d   = estado_q;
        mem_addr_d = mem_addr_q;
        rodada_d   = rodada_q;
        leds_d     = leds_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
                else         estado_d = INICIAL;
            end
            PREPARA: begin
                mem_addr_d = '0;
                rodada_d   = '0;
                leds_d     = '0;
                estado_d   = ESPERA;
            end
            ESPERA: begin
                // a move arriving on the last allowed cycle still counts
                if (jogada_q)           estado_d = REGISTRA;
                else if (fim_timeout_s) estado_d = FIM_TIMEOUT;
                else                    estado_d = ESPERA;
            end
            REGISTRA: begin
                leds_d   = chaves;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (leds_q != mem_data)          estado_d = FIM_ERRO;
                else if (mem_addr_q < rodada_q)  estado_d = PROX_JOGADA;
                else if (rodada_q == ULTIMA)     estado_d = FIM_ACERTO;
                else                             estado_d = PROX_RODADA;
            end
            PROX_JOGADA: begin
                mem_addr_d = mem_addr_q + W_END'(1);
                estado_d   = ESPERA;
            end
            PROX_RODADA: begin
                rodada_d   = rodada_q + W_END'(1);
                mem_addr_d = '0;
                estado_d   = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARA;
                else         estado_d = estado_q;
            end
            default: begin
                estado_d = ESTADO_RESET;
            end
        endcase
    end

    // Moore outputs decoded from the upcoming state so they land in registers
    always_comb begin
        acertou_d    = (estado_d == FIM_ACERTO);
        errou_d      = (estado_d == FIM_ERRO) || (estado_d == FIM_TIMEOUT);
        pronto_d     = estado_final(estado_d);
        db_timeout_d = (estado_d == FIM_TIMEOUT);
    end

    // state, datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= ESTADO_RESET;
            mem_addr_q    <= '0;
            rodada_q      <= '0;
            leds_q        <= '0;
            chaves_prev_q <= '0;
            jogada_q      <= BIT_RESET;
            acertou_q     <= BIT_RESET;
            errou_q       <= BIT_RESET;
            pronto_q      <= BIT_RESET;
            db_timeout_q  <= BIT_RESET;
            db_estado_q   <= 4'h0;
        end else begin
            estado_q      <= estado_d;
            mem_addr_q    <= mem_addr_d;
            rodada_q      <= rodada_d;
            leds_q        <= leds_d;
            chaves_prev_q <= chaves;
            jogada_q      <= jogada_d;
            acertou_q     <= acertou_d;
            errou_q       <= errou_d;
            pronto_q      <= pronto_d;
            db_timeout_q  <= db_timeout_d;
            db_estado_q   <= estado_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign rodada     = rodada_q;
    assign leds       = leds_q;
    assign acertou    = acertou_q;
    assign errou      = errou_q;
    assign pronto     = pronto_q;
    assign db_timeout = db_timeout_q;
    assign db_jogada  = jogada_q;
    assign db_estado  = db_estado_q;

endmodule

// File: tb/tb_jogo_memoria_rodadas.sv
// Self-checking bench for jogo_memoria_rodadas (PROF=4, four buttons, 10-cycle move window).
module tb_jogo_memoria_rodadas;
    localparam int NB = 4;
    localparam int P  = 4;
    localparam int WE = 2;
    localparam int TO = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [NB-1:0] chaves;
    logic [NB-1:0] mem_data;
    logic [WE-1:0] mem_addr;
    logic [WE-1:0] rodada;
    logic [NB-1:0] leds;
    logic          acertou, errou, pronto, db_timeout, db_jogada;
    logic [3:0]    db_estado;

    logic [NB-1:0] rom [P] = '{4'h1, 4'h2, 4'h4, 4'h8};
    assign mem_data = rom[mem_addr];

    int n_cmp = 0;
    int n_err = 0;

    jogo_memoria_rodadas #(
        .N_BOTOES(NB), .PROF(P), .W_END(WE), .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .mem_data(mem_data), .mem_addr(mem_addr), .rodada(rodada), .leds(leds),
        .acertou(acertou), .errou(errou), .pronto(pronto), .db_timeout(db_timeout),
        .db_jogada(db_jogada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_estado(input logic [3:0] alvo, input int budget, input string nome);
        int k = 0;
        while (db_estado !== alvo && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (db_estado !== alvo) begin
            n_err++;
            $display("FAIL %s: state=%h required %h", nome, db_estado, alvo);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; iniciar = 1'b0; chaves = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic start_game;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        wait_estado(4'h2, 4, "start");
    endtask

    // press v after 'atraso' idle ESPERA cycles and stop once the press is under evaluation
    task automatic go_compara(input logic [NB-1:0] v, input int atraso);
        wait_estado(4'h2, 8, "await_espera");
        for (int k = 0; k < atraso; k++) tick();
        chaves = v;
        wait_estado(4'h4, 8, "reach_compara");
        chaves = '0;
    endtask

    task automatic play_move(input logic [NB-1:0] v, input int atraso, output logic [3:0] st);
        go_compara(v, atraso);
        tick();
        st = db_estado;
        if (st == 4'h5 || st == 4'h6) tick();
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({db_estado, mem_addr, rodada, leds, acertou, errou, pronto, db_timeout, db_jogada} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: st=%h addr=%0d rod=%0d leds=%h a=%b e=%b p=%b t=%b j=%b required all zero",
                     db_estado, mem_addr, rodada, leds, acertou, errou, pronto, db_timeout, db_jogada);
        end
        tick();
        n_cmp++;
        if (db_estado !== 4'h0) begin
            n_err++; $display("FAIL idle_hold: state=%h required 0", db_estado);
        end
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        n_cmp++;
        if (db_estado !== 4'h1) begin
            n_err++; $display("FAIL iniciar_prepara: state=%h required 1", db_estado);
        end
        tick();
        n_cmp++;
        if (db_estado !== 4'h2) begin
            n_err++; $display("FAIL prepara_espera: state=%h required 2", db_estado);
        end
    endtask

    task automatic test_full_win;
        logic [3:0] st, esp;
        do_reset(); start_game();
        for (int r = 0; r < P; r++) begin
            for (int i = 0; i <= r; i++) begin
                play_move(4'(1 << i), 0, st);
                esp = (i < r) ? 4'h5 : ((r == P - 1) ? 4'hA : 4'h6);
                n_cmp++;
                if (st !== esp) begin
                    n_err++; $display("FAIL win_step r%0d i%0d: state=%h required %h", r, i, st, esp);
                end
            end
        end
        n_cmp++;
        if ({acertou, pronto, errou, db_estado, rodada, leds} !== {1'b1, 1'b1, 1'b0, 4'hA, 2'd3, 4'h8}) begin
            n_err++;
            $display("FAIL win_final: a=%b p=%b e=%b st=%h rod=%0d leds=%h required 1 1 0 a 3 8",
                     acertou, pronto, errou, db_estado, rodada, leds);
        end
    endtask

    task automatic test_error;
        logic [3:0] st;
        do_reset(); start_game();
        play_move(4'h1, 1, st);
        play_move(4'h1, 0, st);
        play_move(4'h4, 2, st);
        n_cmp++;
        if ({st, errou, acertou, pronto, leds, mem_addr, rodada} !== {4'hE, 1'b1, 1'b0, 1'b1, 4'h4, 2'd1, 2'd1}) begin
            n_err++;
            $display("FAIL error_mid: st=%h e=%b a=%b p=%b leds=%h addr=%0d rod=%0d required e 1 0 1 4 1 1",
                     st, errou, acertou, pronto, leds, mem_addr, rodada);
        end
    endtask

    task automatic test_timeout;
        do_reset(); start_game();
        for (int c = 2; c <= TO; c++) tick();
        n_cmp++;
        if ({db_estado, db_timeout} !== {4'h2, 1'b0}) begin
            n_err++; $display("FAIL timeout_early: st=%h to=%b required 2 0", db_estado, db_timeout);
        end
        tick();
        n_cmp++;
        if ({db_estado, db_timeout, errou, pronto, acertou} !== {4'hD, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_fire: st=%h to=%b e=%b p=%b a=%b required d 1 1 1 0",
                     db_estado, db_timeout, errou, pronto, acertou);
        end
        do_reset(); start_game();
        for (int c = 2; c <= TO - 1; c++) tick();
        chaves = 4'h1;
        tick();
        n_cmp++;
        if ({db_estado, db_jogada} !== {4'h2, 1'b1}) begin
            n_err++; $display("FAIL last_cycle_move: st=%h jog=%b required 2 1", db_estado, db_jogada);
        end
        tick();
        n_cmp++;
        if ({db_estado, db_timeout} !== {4'h3, 1'b0}) begin
            n_err++; $display("FAIL move_beats_timeout: st=%h to=%b required 3 0", db_estado, db_timeout);
        end
        chaves = '0;
    endtask

    task automatic test_held_multihot;
        logic [3:0] st;
        int pulsos = 0;
        do_reset(); start_game();
        chaves = 4'h1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (db_jogada === 1'b1) pulsos++;
        end
        n_cmp++;
        if ({pulsos[7:0], db_estado, rodada} !== {8'd1, 4'hD, 2'd1}) begin
            n_err++;
            $display("FAIL held_button: pulses=%0d st=%h rod=%0d required 1 d 1", pulsos, db_estado, rodada);
        end
        chaves = '0; tick();
        start_game();
        play_move(4'h3, 0, st);
        n_cmp++;
        if ({st, leds, errou} !== {4'hE, 4'h3, 1'b1}) begin
            n_err++; $display("FAIL multi_hot: st=%h leds=%h e=%b required e 3 1", st, leds, errou);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] st;
        do_reset(); start_game();
        play_move(4'h1, 0, st);
        play_move(4'h1, 0, st);
        play_move(4'h2, 0, st);
        play_move(4'h1, 0, st);
        play_move(4'h2, 0, st);
        go_compara(4'h4, 0);
        n_cmp++;
        if ({db_estado, rodada, mem_addr} !== {4'h4, 2'd2, 2'd2}) begin
            n_err++; $display("FAIL mid_setup: st=%h rod=%0d addr=%0d required 4 2 2", db_estado, rodada, mem_addr);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++;
        if ({db_estado, mem_addr, rodada, leds, acertou, errou, pronto, db_timeout, db_jogada} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: st=%h addr=%0d rod=%0d leds=%h a=%b e=%b p=%b t=%b j=%b required all zero",
                     db_estado, mem_addr, rodada, leds, acertou, errou, pronto, db_timeout, db_jogada);
        end
    endtask

    task automatic test_restart;
        logic [3:0] st;
        do_reset(); start_game();
        play_move(4'h2, 0, st);
        n_cmp++;
        if (st !== 4'hE) begin
            n_err++; $display("FAIL restart_setup: state=%h required e", st);
        end
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        n_cmp++;
        if ({db_estado, errou, pronto} !== {4'h1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL restart_prepara: st=%h e=%b p=%b required 1 0 0", db_estado, errou, pronto);
        end
        tick();
        n_cmp++;
        if ({db_estado, rodada, mem_addr, leds} !== {4'h2, 2'd0, 2'd0, 4'h0}) begin
            n_err++;
            $display("FAIL restart_espera: st=%h rod=%0d addr=%0d leds=%h required 2 0 0 0",
                     db_estado, rodada, mem_addr, leds);
        end
        iniciar = 1'b1; tick(); tick(); iniciar = 1'b0;
        n_cmp++;
        if (db_estado !== 4'h2) begin
            n_err++; $display("FAIL iniciar_ignored: state=%h required 2", db_estado);
        end
    endtask

    // random games scored by a round/position model of the rules
    task automatic test_random_games;
        logic [3:0]    st, esp;
        logic [NB-1:0] v, certo;
        int r, i;
        bit fim;
        do_reset(); start_game();
        for (int g = 0; g < 12; g++) begin
            r = 0; i = 0; fim = 1'b0;
            for (int m = 0; m < 12 && !fim; m++) begin
                certo = 4'(1 << i);
                v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : certo;
                play_move(v, int'($urandom_range(0, 5)), st);
                if (v != certo)     begin esp = 4'hE; fim = 1'b1; end
                else if (i < r)     begin esp = 4'h5; end
                else if (r == P-1)  begin esp = 4'hA; fim = 1'b1; end
                else                begin esp = 4'h6; end
                n_cmp++;
                if (st !== esp) begin
                    n_err++;
                    $display("FAIL rand g%0d r%0d i%0d v=%h: state=%h required %h", g, r, i, v, st, esp);
                    fim = 1'b1;
                end else if (fim) begin
                    n_cmp++;
                    if ({leds, rodada, mem_addr} !== {v, 2'(r), 2'(i)}) begin
                        n_err++;
                        $display("FAIL rand_final g%0d: leds=%h rod=%0d addr=%0d required %h %0d %0d",
                                 g, leds, rodada, mem_addr, v, r, i);
                    end
                end
                if (esp == 4'h5) i++;
                if (esp == 4'h6) begin r++; i = 0; end
            end
            if (db_estado == 4'hA || db_estado == 4'hE) begin
                start_game();
            end else begin
                do_reset(); start_game();
            end
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; chaves = '0;
        test_reset();
        test_full_win();
        test_error();
        test_timeout();
        test_held_multihot();
        test_reset_mid();
        test_restart();
        test_random_games();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
